// File: rtl/mux_seq_if.sv
// Handshake bundle for mux_seq: packed channel data and select in, registered word out.
interface mux_seq_if #(
    parameter int W = 8,
    parameter int N = 5
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] d;
    logic [SW-1:0]  s;
    logic           mode;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   y;
    logic [SW-1:0]  ch;
    logic           oor;
    logic           last;
    logic           out_valid;
    logic           out_ready;

    modport slave (
        input  d, s, mode, in_valid, out_ready,
        output in_ready, y, ch, oor, last, out_valid
    );

    modport master (
        output d, s, mode, in_valid, out_ready,
        input  in_ready, y, ch, oor, last, out_valid
    );
endinterface

// File: rtl/mux_seq.sv
// N-channel W-bit registered multiplexer with direct and scan modes and a
// one-deep valid/ready output stage.
module mux_seq #(
    parameter int W = 8,
    parameter int N = 5
) (
    input logic      clk,
    input logic      reset,
    mux_seq_if.slave bus
);
    localparam int SW = $clog2(N);
    localparam logic [SW:0]   NUM  = (SW+1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N-1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_y;
    logic [SW-1:0] r_ch;
    logic          r_oor;
    logic          r_last;
    logic [SW-1:0] r_cnt;
    logic          w_in_ready;
    logic          w_load;
    logic          w_in_range;
    logic          w_cnt_wrap;

    // Unmatched indices fall through to zero, which covers out-of-range selects.
    function automatic logic [W-1:0] sel_word(input logic [N*W-1:0] dv,
                                              input logic [SW-1:0]  idx);
        logic [W-1:0] word;
        word = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SW'(k)) word = dv[k*W +: W];
        end
        return word;
    endfunction

    assign w_in_ready = (r_state == EMPTY) | bus.out_ready;
    assign w_load     = bus.in_valid & w_in_ready;
    assign w_in_range = ({1'b0, bus.s} < NUM);
    assign w_cnt_wrap = (r_cnt == LAST);

    always_comb begin
        w_state_nxt = r_state;
        if (w_load)
            w_state_nxt = FULL;
        else if (bus.out_ready)
            w_state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Scan counter restarts whenever direct mode is seen so each sweep begins at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (!bus.mode)
            r_cnt <= '0;
        else if (w_load)
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y    <= '0;
            r_ch   <= '0;
            r_oor  <= 1'b0;
            r_last <= 1'b0;
        end else if (w_load) begin
            if (bus.mode) begin
                r_y    <= sel_word(bus.d, r_cnt);
                r_ch   <= r_cnt;
                r_oor  <= 1'b0;
                r_last <= w_cnt_wrap;
            end else begin
                r_y    <= sel_word(bus.d, bus.s);
                r_ch   <= bus.s;
                r_oor  <= ~w_in_range;
                r_last <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.y         = r_y;
    assign bus.ch        = r_ch;
    assign bus.oor       = r_oor;
    assign bus.last      = r_last;
    assign bus.out_valid = (r_state == FULL);
endmodule

// File: tb/tb_mux_seq.sv
// Scoreboard bench for mux_seq (W=8, N=5): stimulus queues expected words,
// a negedge monitor pops and compares each accepted output.
module tb_mux_seq;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mux_seq_if #(.W(8), .N(5)) ifc ();

    mux_seq #(.W(8), .N(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] ch;
        logic       oor;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t mk(input logic [7:0] y, input logic [2:0] ch,
                                input logic oor, input logic last);
        exp_t e;
        e.y = y; e.ch = ch; e.oor = oor; e.last = last;
        return e;
    endfunction

    // Channel k of d carries 0x11*k.
    function automatic exp_t scan_exp(input int k);
        return mk(8'(8'h11 * k), 3'(k), 1'b0, (k == 4));
    endfunction

    always @(negedge clk) begin
        if (!reset && ifc.out_valid && ifc.out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_y",    32'(ifc.y),    32'(e.y));
                chk("mon_ch",   32'(ifc.ch),   32'(e.ch));
                chk("mon_oor",  32'(ifc.oor),  32'(e.oor));
                chk("mon_last", 32'(ifc.last), 32'(e.last));
            end
        end
    end

    task automatic step(input logic iv, input logic md, input logic [2:0] sv, input logic ordy);
        ifc.in_valid  = iv;
        ifc.mode      = md;
        ifc.s         = sv;
        ifc.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        ifc.d         = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        ifc.s         = '0;
        ifc.mode      = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y",         32'(ifc.y),         32'h0);
        chk("rst_ch",        32'(ifc.ch),        32'h0);
        chk("rst_oor",       32'(ifc.oor),       32'h0);
        chk("rst_last",      32'(ifc.last),      32'h0);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
        reset = 1'b0;

        // Direct select of channel 3, single-cycle valid.
        q.push_back(mk(8'h33, 3'd3, 1'b0, 1'b0));
        step(1'b1, 1'b0, 3'd3, 1'b1);
        chk("direct_valid_hi", 32'(ifc.out_valid), 32'h1);
        step(1'b0, 1'b0, 3'd0, 1'b1);
        chk("direct_valid_lo", 32'(ifc.out_valid), 32'h0);

        // Out-of-range direct select.
        q.push_back(mk(8'h00, 3'd6, 1'b1, 1'b0));
        step(1'b1, 1'b0, 3'd6, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b1);

        // Back-to-back scan sweep with wrap.
        for (int i = 0; i < 7; i++) begin
            q.push_back(scan_exp(i % 5));
            step(1'b1, 1'b1, 3'd7, 1'b1);
        end
        step(1'b0, 1'b1, 3'd0, 1'b1);

        // Scan stall after channel 2 is loaded.
        step(1'b0, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            q.push_back(scan_exp(i));
            step(1'b1, 1'b1, 3'd0, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 3'd0, 1'b0);
            chk("stall_y",        32'(ifc.y),        32'h22);
            chk("stall_ch",       32'(ifc.ch),       32'd2);
            chk("stall_in_ready", 32'(ifc.in_ready), 32'h0);
        end
        q.push_back(scan_exp(3));
        step(1'b1, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b1, 3'd0, 1'b1);

        // Mode toggle while a scan word is held.
        step(1'b0, 1'b0, 3'd0, 1'b1);
        q.push_back(scan_exp(0));
        step(1'b1, 1'b1, 3'd0, 1'b1);
        q.push_back(scan_exp(1));
        step(1'b1, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b0, 3'd4, 1'b0);
        step(1'b0, 1'b1, 3'd0, 1'b0);
        chk("toggle_hold_y",     32'(ifc.y),         32'h11);
        chk("toggle_hold_ch",    32'(ifc.ch),        32'd1);
        chk("toggle_hold_last",  32'(ifc.last),      32'h0);
        chk("toggle_hold_valid", 32'(ifc.out_valid), 32'h1);
        q.push_back(scan_exp(0));
        step(1'b1, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b1, 3'd0, 1'b1);

        // Reset mid-transfer drops the held word and clears the scan counter.
        step(1'b1, 1'b1, 3'd0, 1'b0);
        chk("pre_rst_valid", 32'(ifc.out_valid), 32'h1);
        chk("pre_rst_y",     32'(ifc.y),         32'h11);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_y",     32'(ifc.y),         32'h0);
        chk("async_rst_valid", 32'(ifc.out_valid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b1, 3'd0, 1'b1);
        q.push_back(scan_exp(0));
        step(1'b1, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b1, 3'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b1);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
